// File: rtl/seq_chunk_adder_ctrl.sv
// seq_chunk_adder_ctrl
//   Adds two WIDTH*CHUNKS-bit operands by sequencing one WIDTH-bit
//   ripple-carry datapath (built from full_adder bit cells) over CHUNKS
//   cycles, least significant chunk first. The carry between chunks lives
//   in a register. Start/busy/done handshake; all outputs are registered.
//
//   Optional feature macro: SEQ_CHUNK_ADDER_OVF_EN
//     When defined, adds output ovf = signed overflow of the full-width add
//     (carry into MSB XOR carry out of MSB), registered alongside cout.

// Single-bit full adder cell used to build the chunk datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of one bit position.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

module seq_chunk_adder_ctrl #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*CHUNKS-1:0]   sum,
    output logic                      cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int TOTAL = WIDTH * CHUNKS;
    localparam int CW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [TOTAL-1:0]     op_a_r;
    logic [TOTAL-1:0]     op_b_r;
    logic [TOTAL-1:0]     acc_r;
    logic                 carry_r;
    logic [CW-1:0]        cnt_r;

    logic [WIDTH-1:0]     chunk_sum_s;
    logic [WIDTH:0]       rc_s;
    logic [TOTAL-1:0]     acc_nx_s;
    logic                 last_s;

    // Ripple-carry chain for one chunk: carry register feeds bit 0.
    assign rc_s[0] = carry_r;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_fa
            full_adder u_fa (
                .a  (op_a_r[g]),
                .b  (op_b_r[g]),
                .ci (rc_s[g]),
                .s  (chunk_sum_s[g]),
                .co (rc_s[g+1])
            );
        end
    endgenerate

    // Accumulator update: shift right by one chunk, new chunk enters at the top.
    always_comb begin
        acc_nx_s = (acc_r >> WIDTH) | (TOTAL'(chunk_sum_s) << (TOTAL - WIDTH));
        last_s   = (cnt_r == CNT_LAST);
    end

    // Next-state logic: IDLE waits for start, RUN counts chunks, DONE lasts one cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy    <= (state_nx_s != IDLE);
            done    <= (state_nx_s == DONE);
        end
    end

    // Operand shift registers, carry, counter and accumulator sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r  <= {TOTAL{1'b0}};
            op_b_r  <= {TOTAL{1'b0}};
            acc_r   <= {TOTAL{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_a_r  <= a;
                        op_b_r  <= b;
                        acc_r   <= {TOTAL{1'b0}};
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        op_a_r  <= op_a_r;
                        op_b_r  <= op_b_r;
                        acc_r   <= acc_r;
                        carry_r <= carry_r;
                        cnt_r   <= cnt_r;
                    end
                end
                RUN: begin
                    op_a_r  <= op_a_r >> WIDTH;
                    op_b_r  <= op_b_r >> WIDTH;
                    acc_r   <= acc_nx_s;
                    carry_r <= rc_s[WIDTH];
                    cnt_r   <= cnt_r + CW'(1);
                end
                default: begin
                    op_a_r  <= op_a_r;
                    op_b_r  <= op_b_r;
                    acc_r   <= acc_r;
                    carry_r <= carry_r;
                    cnt_r   <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: loaded only on the edge that enters DONE so partial sums never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= {TOTAL{1'b0}};
            cout <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            if ((state_r == RUN) && last_s) begin
                sum  <= acc_nx_s;
                cout <= rc_s[WIDTH];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                ovf  <= rc_s[WIDTH] ^ rc_s[WIDTH-1];
`endif
            end else begin
                sum  <= sum;
                cout <= cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                ovf  <= ovf;
`endif
            end
        end
    end

endmodule
